systolic_seq: RTL and testbench
===============================

Name: systolic_seq

Overview:
- Sequencer for the output-stationary DIM x DIM systolic multiply array.
- On a start handshake:
  - pulses accumulator clear;
  - streams K operand words from the A and B operand buffers, which are synchronous 1-cycle-latency SRAMs;
  - skews each lane so lane i enters the array i cycles after lane 0;
  - waits for the wavefront to drain, then pulses done.
- Sits between the job/command front end and the Array edge inputs.

Parameters:
- WIDTH, 32, element width in bits.
- DIM, 4, array rows/columns (lanes per edge).
- KW, 8, width of k_len and of the buffer read addresses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  job request
- ready  out  1  high only in IDLE; job accepted when start && ready at a rising edge
- k_len  in  KW  inner dimension K, sampled on accept
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- acc_clr  out  1  one-cycle accumulator clear to all nodes
- a_rd_en  out  1  A buffer read enable
- a_rd_addr  out  KW  A buffer address
- a_rd_data  in  DIM*WIDTH  A word (lane i = bits i*WIDTH +: WIDTH), valid the cycle after a_rd_en
- b_rd_en, b_rd_addr, b_rd_data: same as the A ports, for B
- a_edge  out  DIM*WIDTH  skewed A lanes to the array row inputs
- a_edge_vld  out  DIM  per-lane valid
- b_edge  out  DIM*WIDTH  skewed B lanes to the array inputs
- b_edge_vld  out  DIM  per-lane valid

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; all counters and skew registers 0.
  - ready=1; busy, done, acc_clr, rd_en, all vld = 0; addresses and edge data = 0.
- States: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE
  - ready=1.
  - On accept: latch k_len, k_cnt=0, acc_clr=1 for the next cycle.
  - Next state is FEED, or DRAIN if k_len==0.
- FEED (k_len cycles)
  - a_rd_en = b_rd_en = 1.
  - a_rd_addr = b_rd_addr = k_cnt; k_cnt increments each cycle.
  - Leave for DRAIN after address k_len-1 is issued.
- DRAIN (exactly 2*DIM-1 cycles)
  - Down-counter loaded with 2*DIM-2 on entry; exit when it is 0.
- DONE (1 cycle): done=1, busy=1; next state IDLE.
- Timing, with the accept edge defining cycle 0:
  - acc_clr in cycle 1.
  - Reads in cycles 1..K.
  - done in cycle K+2*DIM.
- Skew: lane i of a_edge/b_edge equals rd_data lane i delayed by i registers from the data-return cycle.
  - Lane 0 is combinational from rd_data.
  - Lane 0 valid = rd_en delayed 1 cycle.
  - Lane i valid = lane 0 valid delayed i cycles.
  - When a lane's vld is low, its data is forced to 0.
- start while busy: ignored, not queued.
- start held high through DONE: accepted in the following IDLE cycle.
- k_len==0: acc_clr still pulses, no reads are issued, done arrives in cycle 2*DIM.
- k_len is ignored outside the accept cycle.
- Reset mid-job: immediate IDLE, skew lines flushed, no done pulse.

Optional Feature:
- Macro: SYSTOLIC_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_jobs[31:0] (increments on each done) and perf_busy_cyc[31:0] (increments every cycle busy==1).
  - Both counters saturate at all-ones and clear only on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package systolic_pkg:
  - state enum seq_state_e {IDLE, FEED, DRAIN, DONE};
  - default WIDTH/DIM constants;
  - function drain_len(DIM) = 2*DIM-1.
- Sub-module skew_line:
  - parameters WIDTH, DEPTH; inputs d, d_vld; outputs q, q_vld;
  - DEPTH=0 is a pass-through;
  - instantiated 2*DIM times via generate.

Test Plan:
- Basic job, DIM=4, k_len=3, accept at cycle 0:
  - acc_clr in cycle 1; rd addresses 0,1,2 in cycles 1-3;
  - a_edge_vld[0] in cycles 2-4; a_edge_vld[3] in cycles 5-7;
  - done only in cycle 11; ready back in cycle 12.
- Lane check: a_rd_data lane i = 16*k+i:
  - a_edge lane 2 shows 2, 18, 34 in cycles 4, 5, 6;
  - b lanes checked the same way.
- k_len=0: acc_clr in cycle 1, no rd_en, done in cycle 8.
- start held continuously with k_len=1: back-to-back jobs; second accept in cycle 10 (done in cycle 9); start ignored while busy.
- rst low in cycle 3 of a k_len=5 job:
  - all outputs 0 and ready=1 asynchronously; no done;
  - a new job after release behaves as in the basic job.
- SYSTOLIC_SEQ_PERF_EN defined, two jobs with k_len=2 and k_len=4: perf_jobs=2, perf_busy_cyc=(2+8)+(4+8)=22.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIM   = 4;
    localparam int DEF_KW    = 8;

    // Cycles for the last operand to ripple through the skew and the array.
    function automatic int drain_len(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/systolic_seq_skew_line.sv
// skew_line: delays one operand lane by DEPTH registers. DEPTH=0 is a
// pass-through. Output data is forced to zero whenever its valid is low.
module skew_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_vld = d_vld;
            assign q     = d_vld ? d : '0;
        end else begin : g_pipe
            logic [WIDTH-1:0] dat_r [DEPTH];
            logic [DEPTH-1:0] vld_r;

            // Shift data and valid one stage per cycle; last stage drives q.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    // NOTE: the data stages are reset too, so a mid-job reset
                    // leaves nothing stale in the line to leak out later.
                    for (int s = 0; s < DEPTH; s++) dat_r[s] <= '0;
                    vld_r <= '0;
                end else begin
                    dat_r[0] <= d;
                    vld_r[0] <= d_vld;
                    for (int s = 1; s < DEPTH; s++) begin
                        dat_r[s] <= dat_r[s-1];
                        vld_r[s] <= vld_r[s-1];
                    end
                end
            end

            assign q_vld = vld_r[DEPTH-1];
            assign q     = q_vld ? dat_r[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/systolic_seq.sv
// systolic_seq: start/done sequencer for the output-stationary DIM x DIM
// systolic array. Clears accumulators, streams K operand words from the A/B
// buffers (1-cycle read latency), skews lane i by i cycles, drains, then
// pulses done. Optional perf counters: define SYSTOLIC_SEQ_PERF_EN.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIM   = DEF_DIM,
    parameter int KW    = DEF_KW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_clr,
    output logic                 a_rd_en,
    output logic [KW-1:0]        a_rd_addr,
    input  logic [DIM*WIDTH-1:0] a_rd_data,
    output logic                 b_rd_en,
    output logic [KW-1:0]        b_rd_addr,
    input  logic [DIM*WIDTH-1:0] b_rd_data,
    output logic [DIM*WIDTH-1:0] a_edge,
    output logic [DIM-1:0]       a_edge_vld,
    output logic [DIM*WIDTH-1:0] b_edge,
    output logic [DIM-1:0]       b_edge_vld
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_jobs,
    output logic [31:0]          perf_busy_cyc
`endif
);

    localparam int DCW = $clog2(2 * DIM);

    seq_state_e      state, state_nxt;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   k_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic            rd_en;
    logic            data_vld;
    logic            accept;
    logic            k_last;

    assign accept = start && ready;
    assign k_last = (k_cnt == k_len_q - KW'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting to the current state first keeps this free of latches.
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (k_len == '0) ? DRAIN : FEED;
            FEED:    if (k_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            FEED:    rd_en = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    assign a_rd_en   = rd_en;
    assign b_rd_en   = rd_en;
    assign a_rd_addr = rd_en ? k_cnt : '0;
    assign b_rd_addr = rd_en ? k_cnt : '0;

    // Job length latch, read address counter and drain down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len_q   <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                k_len_q <= k_len;
                k_cnt   <= '0;
            end else if (state == FEED) begin
                k_cnt <= k_cnt + KW'(1);
            end
            if (state_nxt == DRAIN && state != DRAIN)
                drain_cnt <= DCW'(drain_len(DIM) - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DCW'(1);
        end
    end

    // Accumulator clear follows the accept edge; read data is valid one cycle after rd_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_clr  <= 1'b0;
            data_vld <= 1'b0;
        end else begin
            acc_clr  <= accept;
            data_vld <= rd_en;
        end
    end

    // Lane i of each edge is delayed by i registers to form the wavefront.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        skew_line #(.WIDTH(WIDTH), .DEPTH(i)) u_a_skew (
            .clk   (clk),
            .rst   (rst),
            .d     (a_rd_data[i*WIDTH +: WIDTH]),
            .d_vld (data_vld),
            .q     (a_edge[i*WIDTH +: WIDTH]),
            .q_vld (a_edge_vld[i])
        );
        skew_line #(.WIDTH(WIDTH), .DEPTH(i)) u_b_skew (
            .clk   (clk),
            .rst   (rst),
            .d     (b_rd_data[i*WIDTH +: WIDTH]),
            .d_vld (data_vld),
            .q     (b_edge[i*WIDTH +: WIDTH]),
            .q_vld (b_edge_vld[i])
        );
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    // Saturating job and busy-cycle counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_jobs     <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (done && perf_jobs != '1)     perf_jobs     <= perf_jobs + 32'd1;
            if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Testbench for systolic_seq: cycle tables for the control outputs plus a
// per-lane scoreboard for the skewed edge data.
`timescale 1ns/1ps
module tb_systolic_seq;
    import systolic_pkg::*;

    localparam int WIDTH = 32;
    localparam int DIM   = 4;
    localparam int KW    = 8;
    localparam logic [31:0] B_BASE = 32'hB000_0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [KW-1:0]        k_len = '0;
    logic                 ready, busy, done, acc_clr;
    logic                 a_rd_en, b_rd_en;
    logic [KW-1:0]        a_rd_addr, b_rd_addr;
    logic [DIM*WIDTH-1:0] a_rd_data = '0;
    logic [DIM*WIDTH-1:0] b_rd_data = '0;
    logic [DIM*WIDTH-1:0] a_edge, b_edge;
    logic [DIM-1:0]       a_edge_vld, b_edge_vld;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]          perf_jobs, perf_busy_cyc;
`endif

    always #5 clk = ~clk;

    systolic_seq #(.WIDTH(WIDTH), .DIM(DIM), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .acc_clr    (acc_clr),
        .a_rd_en    (a_rd_en),
        .a_rd_addr  (a_rd_addr),
        .a_rd_data  (a_rd_data),
        .b_rd_en    (b_rd_en),
        .b_rd_addr  (b_rd_addr),
        .b_rd_data  (b_rd_data),
        .a_edge     (a_edge),
        .a_edge_vld (a_edge_vld),
        .b_edge     (b_edge),
        .b_edge_vld (b_edge_vld)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .perf_jobs     (perf_jobs),
        .perf_busy_cyc (perf_busy_cyc)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand pattern: lane i of word k is base + 16*k + i.
    function automatic logic [31:0] lane_val(input int k, input int i, input logic [31:0] base);
        return base + 32'(16 * k + i);
    endfunction

    function automatic logic [DIM*WIDTH-1:0] word(input int k, input logic [31:0] base);
        logic [DIM*WIDTH-1:0] w;
        for (int i = 0; i < DIM; i++) w[i*WIDTH +: WIDTH] = lane_val(k, i, base);
        return w;
    endfunction

    // Buffer models: 1-cycle latency; garbage when not enabled.
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? word(int'(a_rd_addr), 32'h0)  : {DIM{32'hDEAD_BEEF}};
        b_rd_data <= b_rd_en ? word(int'(b_rd_addr), B_BASE) : {DIM{32'hDEAD_BEEF}};
    end

    // Scoreboard: one queue per lane, entry due in an absolute cycle.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } sb_t;
    sb_t sb [DIM][$];
    int  sb_k = 0;   // word index of the next read, reset by the stimulus per job

    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            for (int i = 0; i < DIM; i++) sb[i].delete();
        end else begin
            for (int i = 0; i < DIM; i++) begin
                if (sb[i].size() != 0 && sb[i][0].due == cyc) begin
                    e = sb[i].pop_front();
                    check($sformatf("a_edge_vld[%0d]", i), a_edge_vld[i], 1'b1);
                    check($sformatf("b_edge_vld[%0d]", i), b_edge_vld[i], 1'b1);
                    check($sformatf("a_edge[%0d]", i), a_edge[i*WIDTH +: WIDTH], e.a);
                    check($sformatf("b_edge[%0d]", i), b_edge[i*WIDTH +: WIDTH], e.b);
                end else begin
                    check($sformatf("a_edge_vld[%0d] idle", i), a_edge_vld[i], 1'b0);
                    check($sformatf("b_edge_vld[%0d] idle", i), b_edge_vld[i], 1'b0);
                    check($sformatf("a_edge[%0d] idle", i), a_edge[i*WIDTH +: WIDTH], 32'h0);
                    check($sformatf("b_edge[%0d] idle", i), b_edge[i*WIDTH +: WIDTH], 32'h0);
                end
            end
            if (a_rd_en) begin
                check("b_rd_en with a_rd_en", b_rd_en, 1'b1);
                check("a_rd_addr seq", a_rd_addr, KW'(sb_k));
                check("b_rd_addr seq", b_rd_addr, KW'(sb_k));
                for (int i = 0; i < DIM; i++)
                    sb[i].push_back('{lane_val(sb_k, i, 32'h0), lane_val(sb_k, i, B_BASE), cyc + 1 + i});
                sb_k++;
            end
        end
    end

    task automatic check_sb_empty(input string tag);
        for (int i = 0; i < DIM; i++)
            check($sformatf("%s sb[%0d] drained", tag, i), 64'(sb[i].size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ready"}, ready, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " acc_clr"}, acc_clr, 1'b0);
        check({tag, " a_rd_en"}, a_rd_en, 1'b0);
        check({tag, " b_rd_en"}, b_rd_en, 1'b0);
        check({tag, " a_rd_addr"}, a_rd_addr, '0);
        check({tag, " b_rd_addr"}, b_rd_addr, '0);
        check({tag, " a_edge_vld"}, a_edge_vld, '0);
        check({tag, " b_edge_vld"}, b_edge_vld, '0);
        check({tag, " a_edge"}, a_edge, '0);
        check({tag, " b_edge"}, b_edge, '0);
    endtask

    // Control-row check used by the hand sequences.
    task automatic check_ctl(input string tag, input int r, input logic e_ready,
                             input logic e_done, input logic e_clr, input logic e_rd);
        string t;
        t = $sformatf("%s c%0d", tag, r);
        check({t, " ready"}, ready, e_ready);
        check({t, " busy"}, busy, !e_ready);
        check({t, " done"}, done, e_done);
        check({t, " acc_clr"}, acc_clr, e_clr);
        check({t, " a_rd_en"}, a_rd_en, e_rd);
        check({t, " b_rd_en"}, b_rd_en, e_rd);
    endtask

    // Basic-job table: K=3, row index = cycle relative to the accept edge.
    typedef struct {
        logic            ready, busy, done, acc_clr, rd_en;
        logic [KW-1:0]   addr;
        logic [DIM-1:0]  vld;
        logic [31:0]     a_l2;   // expected a_edge lane 2 (0 when not valid)
    } vec_t;
    vec_t basic [13];

    task automatic run_basic(input string tag);
        string t;
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd3;
        sb_k  = 0;
        for (int r = 0; r < 13; r++) begin
            if (r > 0) begin
                @(negedge clk);
                if (r == 1) begin
                    start = 1'b0;
                    k_len = 8'hFF;
                end
            end
            t = $sformatf("%s c%0d", tag, r);
            check({t, " ready"}, ready, basic[r].ready);
            check({t, " busy"}, busy, basic[r].busy);
            check({t, " done"}, done, basic[r].done);
            check({t, " acc_clr"}, acc_clr, basic[r].acc_clr);
            check({t, " a_rd_en"}, a_rd_en, basic[r].rd_en);
            if (basic[r].rd_en) check({t, " a_rd_addr"}, a_rd_addr, basic[r].addr);
            check({t, " a_edge_vld"}, a_edge_vld, basic[r].vld);
            check({t, " b_edge_vld"}, b_edge_vld, basic[r].vld);
            check({t, " a_edge[2]"}, a_edge[2*WIDTH +: WIDTH], basic[r].a_l2);
            check({t, " b_edge[2]"}, b_edge[2*WIDTH +: WIDTH],
                  basic[r].vld[2] ? B_BASE + basic[r].a_l2 : 32'h0);
        end
        check_sb_empty(tag);
    endtask

`ifdef SYSTOLIC_SEQ_PERF_EN
    task automatic run_job(input logic [KW-1:0] k);
        @(negedge clk);
        start = 1'b1;
        k_len = k;
        sb_k  = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (int'(k) + 2 * DIM) @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //                ready busy done clr rd addr vld      a_l2
        basic[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};
        basic[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 4'b0000, 32'd0};
        basic[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 4'b0001, 32'd0};
        basic[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 4'b0011, 32'd0};
        basic[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0111, 32'd2};
        basic[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1110, 32'd18};
        basic[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1100, 32'd34};
        basic[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b1000, 32'd0};
        basic[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};
        basic[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};
        basic[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};
        basic[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};
        basic[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0000, 32'd0};

        // Reset state.
        @(negedge clk);
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic job, K=3.
        run_basic("basic");

        // K=0: clear pulses, no reads, done in cycle 2*DIM.
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd0;
        sb_k  = 0;
        for (int r = 0; r < 10; r++) begin
            if (r > 0) @(negedge clk);
            if (r == 1) start = 1'b0;
            check_ctl("k0", r, (r == 0 || r == 9), (r == 8), (r == 1), 1'b0);
        end
        check_sb_empty("k0");

        // start held high, K=1: back-to-back jobs; k_len changes while busy are ignored.
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd1;
        sb_k  = 0;
        for (int r = 0; r < 21; r++) begin
            if (r > 0) @(negedge clk);
            if (r == 1) k_len = 8'd7;
            if (r == 10) begin
                k_len = 8'd1;
                sb_k  = 0;
            end
            if (r == 11) start = 1'b0;
            check_ctl("b2b", r, (r == 0 || r == 10 || r == 20), (r == 9 || r == 19),
                      (r == 1 || r == 11), (r == 1 || r == 11));
        end
        check_sb_empty("b2b");

        // Reset in cycle 3 of a K=5 job.
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd5;
        sb_k  = 0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst pre busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1 check_quiet("midrst async");
        repeat (2) begin
            @(negedge clk);
            check_quiet("midrst held");
        end
        rst = 1'b1;
        run_basic("after_rst");

`ifdef SYSTOLIC_SEQ_PERF_EN
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("perf reset jobs", perf_jobs, 32'd0);
        check("perf reset busy", perf_busy_cyc, 32'd0);
        rst = 1'b1;
        run_job(8'd2);
        check("perf job1 jobs", perf_jobs, 32'd1);
        check("perf job1 busy", perf_busy_cyc, 32'd10);
        run_job(8'd4);
        check("perf jobs", perf_jobs, 32'd2);
        check("perf busy_cyc", perf_busy_cyc, 32'd22);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
